// File: rtl/mpc_cfg_pkg.sv
// Shared definitions for the mpc configuration controller: sequencer state
// encoding, register offsets and CTRL/STATUS bit positions.
package mpc_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISOLATE = 2'd1,
      RESET   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] OFF_PEND   = 4'h0;
   localparam logic [3:0] OFF_CTRL   = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;

   localparam int CTRL_COMMIT  = 0;
   localparam int CTRL_CLR_ERR = 1;
   localparam int CTRL_LOCK    = 2;

   localparam int STAT_BUSY = 4;
   localparam int STAT_ERR  = 5;
   localparam int STAT_LOCK = 6;

   // Assemble the STATUS register image.
   function automatic logic [31:0] status_word(input logic [3:0] cfg,
                                               input logic       busy,
                                               input logic       err,
                                               input logic       lock,
                                               input state_t     st);
      logic [31:0] w;
      w             = '0;
      w[3:0]        = cfg;
      w[STAT_BUSY]  = busy;
      w[STAT_ERR]   = err;
      w[STAT_LOCK]  = lock;
      w[15:8]       = {6'b0, st};
      return w;
   endfunction

endpackage

// File: rtl/mpc_cfg_wb_regs.sv
// Wishbone slave for the mpc configuration controller: address decode,
// single-cycle registered ack, PEND / err / lock registers and read mux.
// Optional feature: MPC_CFG_LOCK_EN adds a write-once lock bit (CTRL[2]).
module mpc_cfg_wb_regs
   import mpc_cfg_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [3:0]  RESET_CFG = 4'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cyc,
   input  logic        stb,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic [31:0] wdata,
   input  logic [31:0] adr,
   output logic        ack,
   output logic [31:0] rdata,
   input  logic [3:0]  configuration,
   input  logic        busy,
   input  state_t      state,
   output logic [3:0]  pending,
   output logic        commit
);

   logic        hit;
   logic        access;
   logic        wr;
   logic        wr_pend;
   logic        wr_ctrl;
   logic        commit_req;
   logic        err_set;
   logic        err_clr;
   logic        err;
   logic        lock;
   logic [31:0] rmux;
   logic        unused_bits;

   // An access is taken only when no ack was given in the previous cycle,
   // so a held strobe produces exactly one ack per transfer.
   assign hit        = cyc & stb & (adr[31:4] == BASE_ADDR[31:4]);
   assign access     = hit & ~ack;
   assign wr         = access & we & sel[0];
   assign wr_pend    = wr & (adr[3:0] == OFF_PEND);
   assign wr_ctrl    = wr & (adr[3:0] == OFF_CTRL);
   assign commit_req = wr_ctrl & wdata[CTRL_COMMIT];
   assign err_set    = commit_req & (busy | lock);
   assign err_clr    = wr_ctrl & wdata[CTRL_CLR_ERR];
   assign unused_bits = ^{sel[3:1], wdata[31:4]};

   // Read mux; undecoded offsets return zero.
   always_comb begin
      rmux = '0;
      case (adr[3:0])
         OFF_PEND:   rmux[3:0] = pending;
         OFF_STATUS: rmux      = status_word(configuration, busy, err, lock, state);
         default:    rmux      = '0;
      endcase
   end

   // Ack and read data are registered together; data is zero outside the ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack   <= 1'b0;
         rdata <= '0;
      end else begin
         ack   <= access;
         rdata <= access ? rmux : '0;
      end
   end

   // PEND, sticky err and the one-cycle commit pulse towards the sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= RESET_CFG;
         err     <= 1'b0;
         commit  <= 1'b0;
      end else begin
         if (wr_pend && !lock)
            pending <= wdata[3:0];
         if (err_set)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
         commit <= commit_req & ~busy & ~lock;
      end
   end

`ifdef MPC_CFG_LOCK_EN
   // Lock can only be set by software; only the bus reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lock <= 1'b0;
      else if (wr_ctrl && wdata[CTRL_LOCK])
         lock <= 1'b1;
   end
`else
   assign lock = 1'b0;
`endif

endmodule

// File: rtl/mpc_cfg_ctrl.sv
// Top of the mpc configuration controller: hosts the Wishbone register block
// and the isolate -> reset -> switch -> release sequencer driving the mpc mux.
// Optional feature: MPC_CFG_LOCK_EN (lock bit, implemented in mpc_cfg_wb_regs).
module mpc_cfg_ctrl
   import mpc_cfg_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          ISO_CYCLES = 8,
   parameter int          RST_CYCLES = 16,
   parameter logic [3:0]  RESET_CFG  = 4'd0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [3:0]  configuration,
   output logic        pad_isolate,
   output logic [3:0]  macro_rst,
   output logic        busy
);

   localparam logic [7:0] ISO_LOAD = 8'(ISO_CYCLES - 1);
   localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

   state_t     state;
   logic [7:0] cnt;
   logic [3:0] pending;
   logic [3:0] target;
   logic       commit;

   mpc_cfg_wb_regs #(
      .BASE_ADDR (BASE_ADDR),
      .RESET_CFG (RESET_CFG)
   ) u_regs (
      .clk           (wb_clk_i),
      .rst           (wb_rst_i),
      .cyc           (wbs_cyc_i),
      .stb           (wbs_stb_i),
      .we            (wbs_we_i),
      .sel           (wbs_sel_i),
      .wdata         (wbs_dat_i),
      .adr           (wbs_adr_i),
      .ack           (wbs_ack_o),
      .rdata         (wbs_dat_o),
      .configuration (configuration),
      .busy          (busy),
      .state         (state),
      .pending       (pending),
      .commit        (commit)
   );

   // Switch sequencer. The target is captured at commit so that PEND writes
   // during a running sequence cannot alter what gets applied; the mux value
   // only changes while the pads are isolated and the macros held in reset.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= IDLE;
         cnt           <= '0;
         target        <= RESET_CFG;
         configuration <= RESET_CFG;
         pad_isolate   <= 1'b0;
         macro_rst     <= 4'hF;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               macro_rst   <= 4'h0;
               pad_isolate <= 1'b0;
               busy        <= 1'b0;
               if (commit && (pending != configuration)) begin
                  state       <= ISOLATE;
                  cnt         <= ISO_LOAD;
                  target      <= pending;
                  pad_isolate <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            ISOLATE: begin
               if (cnt == 8'd0) begin
                  state         <= RESET;
                  macro_rst     <= 4'hF;
                  configuration <= target;
                  cnt           <= RST_LOAD;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            RESET: begin
               if (cnt == 8'd0) begin
                  state     <= RELEASE;
                  macro_rst <= 4'h0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            RELEASE: begin
               state       <= IDLE;
               pad_isolate <= 1'b0;
               busy        <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mpc_cfg_ctrl.sv
// Self-checking bench for mpc_cfg_ctrl: register access, switch sequence
// timing, error handling, decode boundaries, optional lock and async reset.
module tb_mpc_cfg_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] wdat = '0;
   logic [31:0] adr = '0;
   logic        ack;
   logic [31:0] rdat;
   logic [3:0]  configuration;
   logic        pad_isolate;
   logic [3:0]  macro_rst;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   mpc_cfg_ctrl dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .wbs_stb_i     (stb),
      .wbs_cyc_i     (cyc),
      .wbs_we_i      (we),
      .wbs_sel_i     (sel),
      .wbs_dat_i     (wdat),
      .wbs_adr_i     (adr),
      .wbs_ack_o     (ack),
      .wbs_dat_o     (rdat),
      .configuration (configuration),
      .pad_isolate   (pad_isolate),
      .macro_rst     (macro_rst),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One Wishbone transfer; reads pop their expectation from the scoreboard at ack.
   task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
      int n;
      logic [31:0] e;
      string t;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'h1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ack && n < 8);
      check("ack_seen", {31'b0, ack}, 32'd1);
      if (!w) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, rdat, e);
      end
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      bus_cycle(1'b1, BASE + off, d);
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      bus_cycle(1'b0, a, '0);
   endtask

   // Access an address that must not be acknowledged.
   task automatic probe_noack(input string tag, input logic [31:0] a, input logic w);
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = 32'h5; sel = 4'h1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         seen |= ack;
      end
      check(tag, {31'b0, seen}, 32'd0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      logic seen;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_cfg", {28'b0, configuration}, 32'h0);
      check("rst_macro", {28'b0, macro_rst}, 32'hF);
      check("rst_ack", {31'b0, ack}, 32'h0);
      check("rst_pad", {31'b0, pad_isolate}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("macro_release", {28'b0, macro_rst}, 32'h0);
      rd("status_reset", BASE + 32'h8, 32'h0000_0000);

      // Full switch to 5 with timing along the way
      wr(32'h0, 32'h5);
      rd("pend_5", BASE + 32'h0, 32'h5);
      wr(32'h4, 32'h1);
      for (int k = 1; k <= 26; k++) begin
         @(posedge clk); #1;
         case (k)
            1: begin
               check("seq_pad_rise", {31'b0, pad_isolate}, 32'h1);
               check("seq_busy_rise", {31'b0, busy}, 32'h1);
               check("seq_cfg_hold", {28'b0, configuration}, 32'h0);
            end
            8: begin
               check("seq_cfg_late", {28'b0, configuration}, 32'h0);
               check("seq_macro_late", {28'b0, macro_rst}, 32'h0);
            end
            9: begin
               check("seq_cfg_apply", {28'b0, configuration}, 32'h5);
               check("seq_macro_on", {28'b0, macro_rst}, 32'hF);
            end
            24: check("seq_macro_hold", {28'b0, macro_rst}, 32'hF);
            25: begin
               check("seq_macro_off", {28'b0, macro_rst}, 32'h0);
               check("seq_pad_release", {31'b0, pad_isolate}, 32'h1);
               check("seq_busy_late", {31'b0, busy}, 32'h1);
            end
            26: begin
               check("seq_busy_fall", {31'b0, busy}, 32'h0);
               check("seq_pad_fall", {31'b0, pad_isolate}, 32'h0);
            end
            default: ;
         endcase
      end
      rd("status_cfg5", BASE + 32'h8, 32'h0000_0005);

      // Commit and PEND write while busy
      wr(32'h0, 32'h9);
      wr(32'h4, 32'h1);
      wr(32'h4, 32'h1);
      wr(32'h0, 32'hA);
      rd("status_busy_err", BASE + 32'h8, 32'h0000_0135);
      rd("pend_while_busy", BASE + 32'h0, 32'hA);
      wait_idle("busy_timeout_1");
      check("cfg_after_busy", {28'b0, configuration}, 32'h9);
      rd("status_err_idle", BASE + 32'h8, 32'h0000_0029);
      wr(32'h4, 32'h2);
      rd("status_err_clr", BASE + 32'h8, 32'h0000_0009);

      // Commit with PEND equal to configuration is a no-op
      wr(32'h0, 32'h9);
      wr(32'h4, 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         seen |= busy | pad_isolate;
      end
      check("noop_commit", {31'b0, seen}, 32'h0);
      rd("status_noop", BASE + 32'h8, 32'h0000_0009);

      // Decode boundaries
      probe_noack("noack_off10", BASE + 32'h10, 1'b0);
      probe_noack("noack_other", 32'h4000_0000, 1'b1);
      rd("read_offC", BASE + 32'hC, 32'h0);

`ifdef MPC_CFG_LOCK_EN
      wr(32'h4, 32'h4);
      wr(32'h0, 32'h3);
      wr(32'h4, 32'h1);
      repeat (4) @(posedge clk);
      #1;
      check("lock_cfg_hold", {28'b0, configuration}, 32'h9);
      check("lock_no_busy", {31'b0, busy}, 32'h0);
      rd("status_locked", BASE + 32'h8, 32'h0000_0069);
      rd("pend_locked", BASE + 32'h0, 32'h9);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rd("status_unlock", BASE + 32'h8, 32'h0000_0000);
`else
      wr(32'h4, 32'h4);
      rd("status_nolock", BASE + 32'h8, 32'h0000_0009);
`endif

      // Asynchronous reset in the middle of ISOLATE
      wr(32'h0, 32'h3);
      wr(32'h4, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      check("mid_iso_pad", {31'b0, pad_isolate}, 32'h1);
      rst = 1'b1;
      #1;
      check("arst_cfg", {28'b0, configuration}, 32'h0);
      check("arst_pad", {31'b0, pad_isolate}, 32'h0);
      check("arst_macro", {28'b0, macro_rst}, 32'hF);
      check("arst_busy", {31'b0, busy}, 32'h0);
      check("arst_ack", {31'b0, ack}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      rd("status_after_arst", BASE + 32'h8, 32'h0000_0000);
      rd("pend_after_arst", BASE + 32'h0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
